// File: rtl/seq_event_reporter.sv
// seq_event_reporter: turns seq_found rising edges into timestamped
// records in a show-ahead FIFO, with a match counter and drop flag.
module seq_event_reporter #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         seq_found,
  input  logic                         evt_ready,
  input  logic                         clr_overflow,
  output logic                         evt_valid,
  output logic [TS_W-1:0]              evt_timestamp,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [TS_W-1:0]  r_ts;
  logic             r_found_d;
  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic w_event;
  logic w_nempty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_event  = seq_found & ~r_found_d;
  assign w_nempty = (r_level != '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = w_nempty & evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = w_event & (~w_full | w_pop);
  assign w_drop   = w_event & w_full & ~w_pop;

  assign evt_valid     = w_nempty;
  assign evt_timestamp = w_nempty ? r_mem[r_rptr] : '0;
  assign match_count   = r_cnt;
  assign fifo_level    = r_level;
  assign overflow      = r_ovf;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  // One-cycle history of seq_found for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_found_d <= 1'b0;
    else        r_found_d <= seq_found;
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_ts;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating count of every detected edge, stored or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_event && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Sticky drop flag; a drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_ovf <= 1'b0;
    else if (w_drop)       r_ovf <= 1'b1;
    else if (clr_overflow) r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_seq_event_reporter.sv
// tb_seq_event_reporter: vector table plus directed sequences
// for seq_event_reporter with default parameters.
module tb_seq_event_reporter;

  logic        clk;
  logic        rst_n;
  logic        seq_found;
  logic        evt_ready;
  logic        clr_overflow;
  logic        evt_valid;
  logic [15:0] evt_timestamp;
  logic [7:0]  match_count;
  logic [2:0]  fifo_level;
  logic        overflow;

  int n_pass;
  int n_tot;

  seq_event_reporter #(
    .TS_W(16), .CNT_W(8), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seq_found(seq_found),
    .evt_ready(evt_ready),
    .clr_overflow(clr_overflow),
    .evt_valid(evt_valid),
    .evt_timestamp(evt_timestamp),
    .match_count(match_count),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sf;
    logic        rd;
    logic        clr;
    logic        v;
    logic [15:0] ts;
    logic [7:0]  cnt;
    logic [2:0]  lvl;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic sf, input logic rd, input logic clr,
    input logic v, input int ts, input int cnt,
    input int lvl, input logic ovf);
    vec_t e;
    e.sf = sf; e.rd = rd; e.clr = clr; e.v = v;
    e.ts = 16'(ts); e.cnt = 8'(cnt);
    e.lvl = 3'(lvl); e.ovf = ovf;
    vq.push_back(e);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic sf, input logic rd,
                       input logic clr);
    seq_found    = sf;
    evt_ready    = rd;
    clr_overflow = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // four separated rising edges with the consumer stalled
  task automatic fill4;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0); tick;
      drive(0, 0, 0); tick;
    end
  endtask

  int vcnt;

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0);

    // idle after reset: everything stays zero
    do_reset;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle%0d valid", i), 32'(evt_valid), 0);
      chk($sformatf("idle%0d level", i), 32'(fifo_level), 0);
      chk($sformatf("idle%0d count", i), 32'(match_count), 0);
      chk($sformatf("idle%0d ovf", i), 32'(overflow), 0);
      tick;
    end

    //   sf rd clr | v  ts cnt lvl ovf   (row index = cycle)
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0,  0, 0, 0, 0);   // c5 pulse
    add(0, 1, 0, 1,  5, 1, 1, 0);   // c6 head ts5, popped
    add(0, 0, 0, 0,  0, 1, 0, 0);   // c7
    add(1, 0, 0, 0,  0, 1, 0, 0);   // c8 edge, held high
    add(1, 0, 0, 1,  8, 2, 1, 0);
    add(1, 0, 0, 1,  8, 2, 1, 0);
    add(1, 0, 0, 1,  8, 2, 1, 0);
    add(0, 0, 0, 1,  8, 2, 1, 0);   // c12 low
    add(1, 0, 0, 1,  8, 2, 1, 0);   // c13 edge
    add(0, 1, 0, 1,  8, 3, 2, 0);
    add(1, 1, 0, 1, 13, 3, 1, 0);   // c15 edge + pop
    add(0, 1, 0, 1, 15, 4, 1, 0);
    add(0, 0, 0, 0,  0, 4, 0, 0);   // c17
    add(1, 0, 0, 0,  0, 4, 0, 0);   // c18 edge ts18
    add(0, 0, 0, 1, 18, 5, 1, 0);
    add(1, 0, 0, 1, 18, 5, 1, 0);   // ts20
    add(0, 0, 0, 1, 18, 6, 2, 0);
    add(1, 0, 0, 1, 18, 6, 2, 0);   // ts22
    add(0, 0, 0, 1, 18, 7, 3, 0);
    add(1, 0, 0, 1, 18, 7, 3, 0);   // ts24
    add(0, 0, 0, 1, 18, 8, 4, 0);
    add(1, 0, 0, 1, 18, 8, 4, 0);   // c26 dropped
    add(0, 0, 0, 1, 18, 9, 4, 1);
    add(1, 0, 0, 1, 18, 9, 4, 1);   // c28 dropped
    add(0, 1, 0, 1, 18, 10, 4, 1);  // drain
    add(0, 1, 0, 1, 20, 10, 3, 1);
    add(0, 1, 0, 1, 22, 10, 2, 1);
    add(0, 1, 0, 1, 24, 10, 1, 1);
    add(0, 0, 1, 0,  0, 10, 0, 1);  // clear request
    add(0, 0, 0, 0,  0, 10, 0, 0);

    do_reset;
    vcnt = 0;
    foreach (vq[k]) begin
      drive(vq[k].sf, vq[k].rd, vq[k].clr);
      chk($sformatf("v%0d valid", k), 32'(evt_valid), 32'(vq[k].v));
      chk($sformatf("v%0d ts", k), 32'(evt_timestamp), 32'(vq[k].ts));
      chk($sformatf("v%0d count", k), 32'(match_count), 32'(vq[k].cnt));
      chk($sformatf("v%0d level", k), 32'(fifo_level), 32'(vq[k].lvl));
      chk($sformatf("v%0d ovf", k), 32'(overflow), 32'(vq[k].ovf));
      tick;
      vcnt++;
    end
    chk("vector rows", 32'(vcnt), 35);

    // held high for 20 cycles: exactly one event
    do_reset;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0);
      if (evt_valid) vcnt++;
      tick;
    end
    drive(0, 1, 0);
    if (evt_valid) vcnt++;
    chk("hold events", 32'(vcnt), 1);
    chk("hold count", 32'(match_count), 1);

    // full FIFO with edge coinciding with a pop
    do_reset;
    fill4;                             // ts 0,2,4,6
    chk("full level", 32'(fifo_level), 4);
    drive(1, 1, 0); tick;              // ts 8 pushed, ts 0 popped
    chk("pp level", 32'(fifo_level), 4);
    chk("pp ovf", 32'(overflow), 0);
    chk("pp count", 32'(match_count), 5);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0);
      chk($sformatf("pp drain%0d valid", i), 32'(evt_valid), 1);
      chk($sformatf("pp drain%0d ts", i),
          32'(evt_timestamp), 32'(2 * i + 2));
      tick;
    end
    chk("pp empty", 32'(fifo_level), 0);

    // drop and clear in the same cycle: set wins
    fill4;
    drive(1, 0, 1); tick;
    chk("drop+clr ovf", 32'(overflow), 1);
    chk("drop+clr level", 32'(fifo_level), 4);
    drive(0, 0, 1); tick;
    chk("clr ovf", 32'(overflow), 0);

    // saturation of the match counter
    do_reset;
    for (int i = 0; i < 255; i++) begin
      drive(1, 1, 0); tick;
      drive(0, 1, 0); tick;
    end
    chk("sat 255", 32'(match_count), 255);
    for (int i = 0; i < 45; i++) begin
      drive(1, 1, 0); tick;
      drive(0, 1, 0); tick;
    end
    chk("sat 300", 32'(match_count), 255);

    // asynchronous reset with three events queued
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0); tick;
      drive(0, 0, 0); tick;
    end
    chk("pre-rst level", 32'(fifo_level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(evt_valid), 0);
    chk("arst level", 32'(fifo_level), 0);
    chk("arst count", 32'(match_count), 0);
    chk("arst ts", 32'(evt_timestamp), 0);
    tick;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/seq_event_reporter.md
Name: seq_event_reporter

Overview:
Downstream consumer of the 3-bit symbol sequence detector's seq_found output. Converts each rising edge of seq_found into a timestamped event record and buffers it in a small FIFO. Records drain to the system side over a valid/ready interface. Also keeps a saturating total match count and a sticky overflow flag for dropped events.

Parameters:
TS_W, 16, width of the free-running timestamp counter and of each event record
CNT_W, 8, width of the saturating total match counter
DEPTH, 4, event FIFO depth in entries; power of two, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
seq_found  input  1  match indication from the sequence detector, treated as a level; may stay high for many cycles
evt_ready  input  1  consumer ready for the head event
clr_overflow  input  1  single-cycle request to clear the overflow flag
evt_valid  output  1  FIFO non-empty, head event presented
evt_timestamp  output  TS_W  timestamp of the head event; 0 when FIFO empty
match_count  output  CNT_W  total detected rising edges since reset, saturating
fifo_level  output  clog2(DEPTH+1)  number of stored events, 0..DEPTH
overflow  output  1  sticky: at least one event dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, rst_n low):
  - evt_valid=0, evt_timestamp=0, match_count=0, fifo_level=0, overflow=0.
  - Timestamp counter=0, seq_found history register=0, FIFO pointers=0.
  - Reset asserted mid-operation discards all stored events immediately.
- Timestamp counter ts:
  - Increments by 1 every cycle after reset release.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Edge detect:
  - seq_found_d is seq_found registered.
  - An event fires in cycle N when seq_found=1 and seq_found_d=0.
  - Continuous high produces exactly one event.
  - A high-low-high pattern produces two events.
  - seq_found high in the first cycle after reset counts as an event, because seq_found_d resets to 0.
- Capture: an event in cycle N writes ts(N), the counter value visible in cycle N, into the FIFO tail at the clock edge ending cycle N.
- Latency: with the FIFO empty, evt_valid rises in cycle N+1 with evt_timestamp=ts(N).
- FIFO:
  - Show-ahead: evt_valid = (fifo_level != 0), evt_timestamp = head entry.
  - Pop occurs on a clock edge where evt_valid=1 and evt_ready=1.
  - evt_ready is ignored while evt_valid=0.
  - Order is strictly first-in first-out.
- Simultaneous push and pop:
  - Not full: both happen, fifo_level unchanged.
  - Full: the pop frees the slot and the push is accepted, level stays DEPTH, no drop.
  - Empty: no pop is possible; the push is stored and the level becomes 1.
- Full, no pop in the same cycle: the event is not stored, overflow set to 1, and FIFO contents are unchanged.
- match_count:
  - Increments on every event, stored or dropped.
  - Holds at 2^CNT_W-1 once reached.
- overflow:
  - Cleared by clr_overflow=1 on the next edge.
  - If a drop and clr_overflow coincide, overflow stays 1 (set wins).
- Pointers: wrap modulo DEPTH. fifo_level is updated registered, consistent with evt_valid in the same cycle.
- Outputs are registered or derived from registered state only; no combinational path from seq_found or evt_ready to any output.

Test Plan:
- Reset release with seq_found=0 for 10 cycles:
  - evt_valid=0, match_count=0, fifo_level=0, overflow=0 throughout.
- seq_found pulsed high for 1 cycle at cycle 5 after reset, evt_ready=1:
  - evt_valid=1 in cycle 6 only, evt_timestamp=5, match_count=1, fifo_level returns to 0 in cycle 7.
- seq_found held high for 20 cycles:
  - Exactly one event, match_count=1.
  - Toggling 1,0,1 gives two events whose timestamps differ by 2.
- evt_ready=0, 6 separate rising edges (DEPTH=4):
  - fifo_level=4, overflow=1, match_count=6.
  - Draining returns the first 4 timestamps in order; clr_overflow then clears overflow.
- FIFO full, edge in same cycle as pop:
  - Level stays 4, no overflow, new timestamp appears as the 4th drained entry.
  - Separately, drop coincident with clr_overflow leaves overflow=1.
- 300 edges with CNT_W=8:
  - match_count=255 and holds.
  - rst_n asserted with 3 events queued: evt_valid=0, fifo_level=0 asynchronously before the next clock.
